// File: rtl/pad_command_reader.sv
`default_nettype none
// ============================================================================
// Module      : pad_command_reader
// Description : Polls an NES-style serial pad, debounces the button word over
//               two consecutive polls and derives the player movement commands.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_command_reader #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       right,
  output logic       left,
  output logic       jump,
  output logic       squat,
  output logic       defend
);

  localparam int PCW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
  localparam int PHW = $clog2(2 * CLK_DIV);

  localparam logic [PCW-1:0] c_poll_last = PCW'(POLL_PERIOD - 1);
  localparam logic [PCW-1:0] c_poll_pre  = PCW'(POLL_PERIOD - 2);
  localparam logic [PHW-1:0] c_latch_end = PHW'(2 * CLK_DIV - 1);
  localparam logic [PHW-1:0] c_half_end  = PHW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [PHW-1:0]   phase_q, phase_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       prev_raw_q;
  logic [7:0]       raw;
  logic             sync1_q, sync2_q;
  logic             start;
  logic             pad_latch_q, pad_clk_q;
  logic [7:0]       buttons_q;
  logic             valid_q, right_q, left_q, jump_q, squat_q, defend_q;

  // The poll begins on the edge where poll_cnt arrives at its last value, so
  // the decision is taken one count early while the FSM is still idle.
  assign poll_cnt_d = (poll_cnt_q == c_poll_last) ? '0 : poll_cnt_q + PCW'(1);
  assign start      = (poll_cnt_q == c_poll_pre) && (state_q == IDLE);
  assign raw        = ~shift_q;

  // Two-flop synchronizer for the asynchronous pad data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_data;
      sync2_q <= sync1_q;
    end
  end

  // Sequencer next-state: phase timing, bit counting and serial capture.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + PHW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (start) begin
          state_d   = LATCH;
          bit_cnt_d = 3'd0;
        end
      end
      LATCH: begin
        if (phase_q == c_latch_end) begin
          state_d = SHIFT_LO;
          phase_d = '0;
        end
      end
      SHIFT_LO: begin
        if (phase_q == c_half_end) begin
          shift_d[bit_cnt_q] = sync2_q;
          state_d            = SHIFT_HI;
          phase_d            = '0;
        end
      end
      SHIFT_HI: begin
        if (phase_q == c_half_end) begin
          phase_d = '0;
          if (bit_cnt_q == 3'd7) begin
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = SHIFT_LO;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Sequencer state and registered pad control lines (glitch-free outputs).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      poll_cnt_q  <= '0;
      phase_q     <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      pad_latch_q <= (state_d == LATCH);
      pad_clk_q   <= (state_d != SHIFT_LO);
    end
  end

  // Debounce and command mapping: a word is accepted only when two
  // consecutive polls agree; jump fires on a rising edge of Up|A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_raw_q <= 8'h00;
      buttons_q  <= 8'h00;
      valid_q    <= 1'b0;
      right_q    <= 1'b0;
      left_q     <= 1'b0;
      jump_q     <= 1'b0;
      squat_q    <= 1'b0;
      defend_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      if (state_q == DONE) begin
        valid_q    <= 1'b1;
        prev_raw_q <= raw;
        if (raw == prev_raw_q) begin
          buttons_q <= raw;
          right_q   <= raw[7];
          left_q    <= raw[6] & ~raw[7];
          squat_q   <= raw[5] & ~raw[4];
          defend_q  <= raw[1];
          jump_q    <= (raw[4] | raw[0]) & ~(buttons_q[4] | buttons_q[0]);
        end
      end
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign right     = right_q;
  assign left      = left_q;
  assign jump      = jump_q;
  assign squat     = squat_q;
  assign defend    = defend_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_command_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_command_reader
// Description : Directed self-checking bench for pad_command_reader with a
//               behavioural NES pad model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pad_command_reader;

  logic       clk;
  logic       rst_n;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       right, left, jump, squat, defend;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] pad_word = 8'h00;
  logic [3:0] pad_idx  = 4'd0;

  int  jump_cnt  = 0;
  bit  jump_long = 0;
  bit  jump_prev = 0;
  bit  seen_02   = 0;
  bit  seen_def  = 0;

  pad_command_reader #(
    .CLK_DIV     (2),
    .POLL_PERIOD (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .valid     (valid),
    .right     (right),
    .left      (left),
    .jump      (jump),
    .squat     (squat),
    .defend    (defend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model: latch resets the bit pointer, each pad_clk rise advances it.
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_idx <= 4'd0;
    else if (pad_idx < 4'd8) pad_idx <= pad_idx + 4'd1;
  end
  assign pad_data = (pad_idx < 4'd8) ? ~pad_word[pad_idx[2:0]] : 1'b0;

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    if (jump) jump_cnt++;
    if (jump && jump_prev) jump_long = 1;
    jump_prev = jump;
    if (buttons == 8'h02) seen_02 = 1;
    if (defend) seen_def = 1;
  end

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int  first_latch = -1;
    int  latch_hi    = 0;
    int  clk_lo      = 0;
    int  clk_fall    = 0;
    int  valid_at    = -1;
    bit  clk_prev    = 1;
    rst_n    = 1'b0;
    pad_word = 8'h00;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({pad_latch, pad_clk, buttons, valid, right, left, jump, squat, defend} !== 15'b0_1_00000000_000000)
      $display("FAIL reset_during: got latch=%b clk=%b btn=%h v=%b cmds=%b%b%b%b%b", pad_latch, pad_clk,
               buttons, valid, right, left, jump, squat, defend);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int n = 1; n <= 101; n++) begin
      @(posedge clk);
      #1;
      if (pad_latch) begin
        latch_hi++;
        if (first_latch < 0) first_latch = n;
      end
      if (!pad_clk) clk_lo++;
      if (clk_prev && !pad_clk) clk_fall++;
      clk_prev = pad_clk;
      if (valid && valid_at < 0) valid_at = n;
      if (n == 62) begin
        total_cnt++;
        if ({pad_latch, pad_clk, buttons, valid} !== 11'b0_1_00000000_0)
          $display("FAIL reset_after: got latch=%b clk=%b btn=%h v=%b want 0 1 00 0", pad_latch, pad_clk, buttons, valid);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (first_latch !== 63) $display("FAIL first_latch_cycle: got %0d want 63", first_latch);
    else pass_cnt++;
    total_cnt++;
    if (latch_hi !== 4) $display("FAIL latch_width: got %0d want 4", latch_hi);
    else pass_cnt++;
    total_cnt++;
    if (clk_lo !== 16 || clk_fall !== 8)
      $display("FAIL pad_clk_pulses: got low=%0d falls=%0d want 16 8", clk_lo, clk_fall);
    else pass_cnt++;
    total_cnt++;
    if (valid_at !== 100) $display("FAIL valid_latency: got cycle %0d want 100", valid_at);
    else pass_cnt++;
  endtask

  task automatic test_right();
    bit ok;
    pad_word = 8'h80;
    wait_valid(ok);
    total_cnt++;
    if (!ok || buttons !== 8'h00 || right !== 1'b0)
      $display("FAIL right_poll1: got ok=%b btn=%h right=%b want 1 00 0", ok, buttons, right);
    else pass_cnt++;
    wait_valid(ok);
    total_cnt++;
    if (!ok || buttons !== 8'h80 || right !== 1'b1 || left !== 1'b0)
      $display("FAIL right_poll2: got ok=%b btn=%h right=%b left=%b want 1 80 1 0", ok, buttons, right, left);
    else pass_cnt++;
  endtask

  task automatic test_right_wins();
    bit ok;
    pad_word = 8'hC0;
    wait_valid(ok);
    total_cnt++;
    if (!ok || buttons !== 8'h80)
      $display("FAIL rl_poll1_hold: got ok=%b btn=%h want 1 80", ok, buttons);
    else pass_cnt++;
    wait_valid(ok);
    total_cnt++;
    if (!ok || buttons !== 8'hC0 || right !== 1'b1 || left !== 1'b0)
      $display("FAIL right_wins: got ok=%b btn=%h right=%b left=%b want 1 C0 1 0", ok, buttons, right, left);
    else pass_cnt++;
  endtask

  task automatic test_up_down();
    bit ok;
    int j0;
    j0 = jump_cnt;
    pad_word = 8'h30;
    wait_valid(ok);
    wait_valid(ok);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (!ok || buttons !== 8'h30 || squat !== 1'b0 || right !== 1'b0)
      $display("FAIL up_down: got ok=%b btn=%h squat=%b right=%b want 1 30 0 0", ok, buttons, squat, right);
    else pass_cnt++;
    total_cnt++;
    if (jump_cnt - j0 !== 1) $display("FAIL up_jump: got %0d pulses want 1", jump_cnt - j0);
    else pass_cnt++;
    pad_word = 8'h20;
    wait_valid(ok);
    wait_valid(ok);
    total_cnt++;
    if (!ok || squat !== 1'b1 || buttons !== 8'h20)
      $display("FAIL squat_down: got ok=%b btn=%h squat=%b want 1 20 1", ok, buttons, squat);
    else pass_cnt++;
  endtask

  task automatic test_jump_hold();
    bit ok;
    int j0;
    pad_word = 8'h00;
    repeat (2) wait_valid(ok);
    j0 = jump_cnt;
    jump_long = 0;
    pad_word = 8'h01;
    repeat (5) wait_valid(ok);
    total_cnt++;
    if (!ok || jump_cnt - j0 !== 1 || jump_long !== 1'b0)
      $display("FAIL jump_hold: got ok=%b pulses=%0d long=%b want 1 1 0", ok, jump_cnt - j0, jump_long);
    else pass_cnt++;
    pad_word = 8'h00;
    repeat (2) wait_valid(ok);
    total_cnt++;
    if (!ok || buttons !== 8'h00 || jump_cnt - j0 !== 1)
      $display("FAIL jump_release: got ok=%b btn=%h pulses=%0d want 1 00 1", ok, buttons, jump_cnt - j0);
    else pass_cnt++;
    pad_word = 8'h01;
    repeat (2) wait_valid(ok);
    repeat (2) @(negedge clk);
    total_cnt++;
    if (!ok || jump_cnt - j0 !== 2 || jump_long !== 1'b0)
      $display("FAIL jump_repress: got ok=%b pulses=%0d long=%b want 1 2 0", ok, jump_cnt - j0, jump_long);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    bit ok;
    pad_word = 8'h00;
    repeat (2) wait_valid(ok);
    seen_02  = 0;
    seen_def = 0;
    pad_word = 8'h02;
    wait_valid(ok);
    pad_word = 8'h00;
    repeat (2) wait_valid(ok);
    total_cnt++;
    if (!ok || seen_02 !== 1'b0 || seen_def !== 1'b0 || buttons !== 8'h00)
      $display("FAIL glitch_reject: got ok=%b seen02=%b def=%b btn=%h want 1 0 0 00", ok, seen_02, seen_def, buttons);
    else pass_cnt++;
    pad_word = 8'h02;
    repeat (2) wait_valid(ok);
    total_cnt++;
    if (!ok || buttons !== 8'h02 || defend !== 1'b1)
      $display("FAIL defend_accept: got ok=%b btn=%h defend=%b want 1 02 1", ok, buttons, defend);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit found = 0;
    int first_latch = -1;
    int vcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!pad_clk) begin
        found = 1;
        break;
      end
    end
    total_cnt++;
    if (!found) $display("FAIL mid_shift_wait: pad_clk never went low within 200 cycles");
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({pad_latch, pad_clk, buttons, valid, right, left, jump, squat, defend} !== 15'b0_1_00000000_000000)
      $display("FAIL mid_reset_clear: got latch=%b clk=%b btn=%h v=%b cmds=%b%b%b%b%b", pad_latch, pad_clk,
               buttons, valid, right, left, jump, squat, defend);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(posedge clk);
      #1;
      if (pad_latch && first_latch < 0) first_latch = n;
      if (valid) vcnt++;
    end
    total_cnt++;
    if (first_latch !== 63 || vcnt !== 0)
      $display("FAIL mid_reset_relatch: got latch cycle %0d valids %0d want 63 0", first_latch, vcnt);
    else pass_cnt++;
    wait_valid(ok);
    total_cnt++;
    if (!ok || buttons !== 8'h00 || defend !== 1'b0)
      $display("FAIL mid_reset_first_poll: got ok=%b btn=%h defend=%b want 1 00 0", ok, buttons, defend);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_right();
    test_right_wins();
    test_up_down();
    test_jump_hold();
    test_glitch();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pad_command_reader.md
# pad_command_reader

Serial gamepad front end that produces the movement command interface consumed by the player-motion logic. It periodically polls an NES-style 8-bit shift-register controller (latch/clock/data), synchronizes and debounces the button word, and drives registered `right`, `left`, `jump`, `squat`, `defend` commands plus the raw button vector. One instance per player, clocked on the game clock.

## Interface
- `CLK_DIV`, default 300: `clk` cycles per `pad_clk` half-phase; latch pulse is 2*CLK_DIV cycles.
- `POLL_PERIOD`, default 833333: `clk` cycles between poll starts. Must exceed 18*CLK_DIV+4.
- `clk`  in  1  game clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pad_data`  in  1  serial data from the pad, active-low (0 = pressed), asynchronous to `clk`.
- `pad_latch`  out  1  parallel-load strobe to the pad, active-high.
- `pad_clk`  out  1  shift clock to the pad, idles high; the pad advances on the rising edge.
- `buttons`  out  8  debounced state, 1 = pressed: [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right.
- `valid`  out  1  one-cycle pulse at each completed poll.
- `right`, `left`, `squat`, `defend`  out  1 each  level commands.
- `jump`  out  1  one-cycle command pulse.

## Operation
- `pad_data` passes through a 2-FF synchronizer before any use.
- Free-running `poll_cnt` counts 0..POLL_PERIOD-1 and wraps. A poll starts when `poll_cnt == POLL_PERIOD-1` and the FSM is in IDLE; if the FSM is busy at that point, that poll is skipped.
- FSM states: IDLE -> LATCH -> SHIFT_LO -> SHIFT_HI -> (SHIFT_LO ×8 bits total) -> DONE -> IDLE.
  - IDLE: `pad_latch`=0, `pad_clk`=1.
  - LATCH: `pad_latch`=1 for 2*CLK_DIV cycles.
  - SHIFT_LO: `pad_clk`=0 for CLK_DIV cycles. On its last cycle, shift the synchronized `pad_data` into bit index `bit_cnt` (0 first, LSB = A).
  - SHIFT_HI: `pad_clk`=1 for CLK_DIV cycles. Increment `bit_cnt`. After bit 7's high phase, go to DONE. Eight clock pulses are issued in total.
  - DONE: one cycle. Compute `raw = ~shift_reg`.
- Debounce, on leaving DONE:
  - if `raw == prev_raw`, then `buttons <= raw`; otherwise `buttons` holds.
  - `prev_raw <= raw` unconditionally.
  - A pattern must therefore be seen in two consecutive polls to be accepted.
- Command mapping, registered and updated on the same edge as `buttons`:
  - `right` = Right.
  - `left` = Left & ~Right (Right wins).
  - `squat` = Down & ~Up.
  - `defend` = B.
  - `jump` = 1 for exactly one cycle when (Up|A) of the newly accepted word is 1 and (Up|A) of the previously accepted word was 0. Holding the button produces no further pulses.
- Start and Select appear only on `buttons`.

## Timing
- Reset values: all outputs 0 except `pad_clk`=1. `poll_cnt`, `bit_cnt`, `shift_reg`, `prev_raw` are 0; FSM is in IDLE.
- Reset is asynchronous. Asserting it mid-poll aborts immediately: lines return to idle and state is cleared. No partial word is ever accepted.
- After reset release, the first `pad_latch` rise happens on the clock edge at which `poll_cnt` reaches POLL_PERIOD-1, i.e. cycle 63 when POLL_PERIOD=64.
- Poll length from LATCH entry to the end of DONE is 18*CLK_DIV+1 cycles.
- `valid`, updated `buttons` and commands, and `jump` all become visible in the cycle after DONE. `valid` is high for 1 cycle on every poll, whether or not the word was accepted.
- Sampling point: the synchronized `pad_data` at the end of the low phase, so the pad has settled for at least CLK_DIV-2 cycles.

## Test plan
Bench parameters: CLK_DIV=2, POLL_PERIOD=64. The pad model loads its word on `pad_latch` high, shifts on the `pad_clk` rising edge, and drives ~bit.
- Reset: all outputs 0 and `pad_clk`=1 during and after reset. First `pad_latch` is high for 4 cycles starting at cycle 63. Eight `pad_clk` low pulses of 2 cycles each follow, then `valid` fires 37 cycles after latch rise.
- Pad holds 0x80 (Right): after poll 1, `buttons`=0x00. After poll 2, `buttons`=0x80 and `right`=1. `valid` pulses on every poll.
- Pad holds 0xC0: `right`=1, `left`=0. Pad holds 0x30 (Up+Down): `squat`=0 and `jump` pulses once.
- Pad holds 0x01 (A) for 5 polls: exactly one 1-cycle `jump` pulse. Release for 2 polls, press again: a second pulse.
- Pad shows 0x02 for a single poll between 0x00 polls: `buttons` never equals 0x02 and `defend` stays 0.
- `rst_n` pulsed low mid-SHIFT: outputs clear immediately and `pad_clk`=1, `pad_latch`=0. Next latch occurs at cycle 63 after release.
